dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the far side of the Memory stage's load/store port.
- Accepts one load or store request at a time and models a configurable multi-cycle access latency.
- Performs word or byte (a_type) accesses and returns a one-cycle response.
- Drives a busy signal to the hazard unit so the pipeline stalls until the response is ready.

Parameters:
- WIDTH, 32, data and address width.
- ADDR_BITS, 12, byte-address bits used for indexing; storage is 2^(ADDR_BITS-2) words.
- LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  CPU clock, rising edge.
- rst  in  1  reset: asynchronous, active-low (asserted when 0).
- req_valid  in  1  Memory stage presents a request.
- req_ready  out  1  responder can accept this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_atype  in  1  1 = byte access, 0 = word access.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data; byte stores use bits [7:0].
- rsp_valid  out  1  response strobe, one cycle.
- rsp_rdata  out  WIDTH  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned word access, qualified by rsp_valid.
- busy  out  1  stall request to the hazard unit.

Behaviour:
- Reset values (rst=0, immediate, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, latency counter=0. Memory contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept when req_valid=1. At that edge, latch we, atype, addr and wdata.
  - Counter loads LATENCY-1.
  - Go to WAIT if LATENCY>1, otherwise go directly to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter is 1, go to RESP on the next edge.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE. req_ready=0.
- Latency: accept at edge n gives rsp_valid high during cycle n+LATENCY. Maximum throughput is one request per LATENCY+1 cycles.
- Request inputs are ignored while not in IDLE. Latched values govern the access.
- busy = (state==IDLE && req_valid) || state==WAIT. busy is 0 in RESP so the pipeline advances in the cycle the data is valid.
- Indexing: word index = addr[ADDR_BITS-1:2]. Upper address bits are ignored, so addresses wrap modulo 2^ADDR_BITS.
- Word load: rdata = mem[index].
- Byte load: rdata = zero-extended byte lane addr[1:0], little-endian (lane 0 = bits [7:0]).
- Word store: writes all 32 bits.
- Byte store: writes only lane addr[1:0]; other lanes are preserved.
- Store commit: the write occurs on the clock edge that enters RESP. A store response has rdata=0.
- Misaligned word access (atype=0, addr[1:0]!=0):
  - no write;
  - rdata=0, rsp_err=1 in the RESP cycle;
  - latency unchanged.
- Byte accesses are never misaligned.
- Reset mid-operation (rst low in WAIT or RESP):
  - return to IDLE immediately;
  - a store not yet committed is dropped;
  - no rsp_valid is produced for the aborted request.
- rsp_rdata and rsp_err hold 0 when rsp_valid=0.

Decomposition:
- Package dmem_pkg contains:
  - state_t enum {IDLE, WAIT, RESP};
  - atype_t enum {A_WORD=0, A_BYTE=1};
  - localparam LAT_W=4 (counter width).
- Sub-module dmem_array: word storage with a synchronous write carrying a 4-bit byte enable, and combinational read.
- dmem_responder: owns the FSM, counter, lane select and misalignment check.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release, keep req_valid=0 -> req_ready=1, busy=0, rsp_valid=0 throughout.
- Word store/load, LATENCY=2: store 0xDEADBEEF to 0x010 at cycle 0 -> rsp_valid at cycle 2, busy high for cycles 0-1. Then load 0x010 -> rdata=0xDEADBEEF.
- Byte lanes: word 0x11223344 at 0x020; byte-store 0xAB to 0x022; word-load 0x020 -> 0x11AB3344. Byte-load 0x023 -> 0x00000011.
- Misaligned word store 0x55 to 0x031 -> rsp_err=1, rdata=0; a following load of 0x030 returns the prior value unchanged.
- Wrap, LATENCY=1 build: store 0x12345678 to 0x0000_1004 (ADDR_BITS=12) -> a load of 0x004 returns 0x12345678; rsp_valid arrives one cycle after accept.
- Reset mid-op: accept a store of 0xCAFEF00D to 0x040 with LATENCY=3, pull rst low in the first WAIT cycle -> no rsp_valid; after release, a load of 0x040 returns the old value.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder slice.
//   state_t  - responder FSM states (IDLE, WAIT, RESP)
//   atype_t  - access size (A_WORD = 32-bit, A_BYTE = 8-bit)
//   LAT_W    - width of the latency down-counter
//   lane_be  - byte-enable pattern for an access of a given size and lane
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    A_WORD = 1'b0,
    A_BYTE = 1'b1
  } atype_t;

  localparam int LAT_W = 4;

  // Word accesses touch all four lanes; byte accesses touch only the addressed lane.
  function automatic logic [3:0] lane_be(input atype_t at, input logic [1:0] lane);
    logic [3:0] be;
    case (at)
      A_WORD:  be = 4'b1111;
      A_BYTE:  be = 4'b0001 << lane;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store port between the Memory stage and the
// data-memory responder, plus the busy line to the hazard unit.
//   req_valid/req_ready       - request handshake
//   req_we/req_atype          - store flag, byte-access flag
//   req_addr/req_wdata        - byte address, store data
//   rsp_valid/rsp_rdata/rsp_err - one-cycle response strobe, load data, misalignment flag
//   busy                      - stall request
// Modports: master = Memory stage side, slave = responder side.
interface dmem_responder_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic             req_atype;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic             busy;

  modport master (
    output req_valid, req_we, req_atype, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_atype, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage for the data-memory responder.
//   clk   - write clock (rising edge)
//   we    - write strobe
//   be    - per-byte write enable, lane 0 = bits [7:0]
//   addr  - word index (shared by read and write)
//   wdata - write data
//   rdata - combinational read of the addressed word
// Contents are deliberately not reset.
module dmem_array #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [ADDR_BITS-3:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  localparam int DEPTH = 1 << (ADDR_BITS - 2);

  logic [WIDTH-1:0] mem_r [0:DEPTH-1];

  // Byte-enabled synchronous write; disabled lanes keep their contents.
  always_ff @(posedge clk) begin
    if (we && be[0]) mem_r[addr][7:0]   <= wdata[7:0];
    if (we && be[1]) mem_r[addr][15:8]  <= wdata[15:8];
    if (we && be[2]) mem_r[addr][23:16] <= wdata[23:16];
    if (we && be[3]) mem_r[addr][31:24] <= wdata[31:24];
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with a fixed
// multi-cycle access latency.
//   clk  - CPU clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - dmem_responder_if.slave (request, response and busy signals)
// Parameters: WIDTH (data/address width), ADDR_BITS (byte-address bits used
// for indexing), LATENCY (accept-to-response cycles, 1..15).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  state_t                 state_r;
  state_t                 state_next_s;
  logic [LAT_W-1:0]       cnt_r;
  logic [LAT_W-1:0]       cnt_next_s;

  logic                   lat_we_r;
  atype_t                 lat_atype_r;
  logic [ADDR_BITS-1:0]   lat_addr_r;
  logic [WIDTH-1:0]       lat_wdata_r;

  logic                   req_ready_r;
  logic                   rsp_valid_r;
  logic                   rsp_err_r;
  logic [WIDTH-1:0]       rsp_rdata_r;

  logic                   accept_s;
  logic                   eff_we_s;
  atype_t                 eff_atype_s;
  logic [ADDR_BITS-1:0]   eff_addr_s;
  logic [WIDTH-1:0]       eff_wdata_s;
  logic                   misaligned_s;
  logic                   enter_resp_s;
  logic                   mem_we_s;
  logic [3:0]             mem_be_s;
  logic [WIDTH-1:0]       mem_wdata_s;
  logic [WIDTH-1:0]       mem_rdata_s;
  logic [7:0]             byte_s;
  logic [WIDTH-1:0]       load_data_s;
  logic [WIDTH-1:0]       rsp_rdata_next_s;
  logic                   rsp_err_next_s;
  logic                   unused_addr_s;

  // Address bits above ADDR_BITS wrap away and are intentionally ignored.
  assign unused_addr_s = ^bus.req_addr[WIDTH-1:ADDR_BITS];

  assign accept_s = (state_r == IDLE) && bus.req_valid;

  // Next-state and latency-counter logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_next_s = LAT_W'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_next_s = WAIT;
          end else begin
            state_next_s = RESP;
          end
        end else begin
          state_next_s = IDLE;
          cnt_next_s   = cnt_r;
        end
      end
      WAIT: begin
        cnt_next_s = cnt_r - LAT_W'(1);
        // <= rather than == so a corrupted zero count cannot strand the FSM.
        if (cnt_r <= LAT_W'(1)) begin
          state_next_s = RESP;
        end else begin
          state_next_s = WAIT;
        end
      end
      RESP: begin
        state_next_s = IDLE;
        cnt_next_s   = {LAT_W{1'b0}};
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {LAT_W{1'b0}};
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {LAT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Request fields are taken from the port in the accept cycle (needed when
  // LATENCY=1 enters RESP directly) and from the latched copy afterwards.
  always_comb begin
    if (state_r == IDLE) begin
      eff_we_s    = bus.req_we;
      eff_atype_s = atype_t'(bus.req_atype);
      eff_addr_s  = bus.req_addr[ADDR_BITS-1:0];
      eff_wdata_s = bus.req_wdata;
    end else begin
      eff_we_s    = lat_we_r;
      eff_atype_s = lat_atype_r;
      eff_addr_s  = lat_addr_r;
      eff_wdata_s = lat_wdata_r;
    end
  end

  assign misaligned_s = (eff_atype_s == A_WORD) && (eff_addr_s[1:0] != 2'b00);
  assign enter_resp_s = (state_next_s == RESP);
  // Gated by rst so nothing commits while reset is held.
  assign mem_we_s     = rst && enter_resp_s && eff_we_s && !misaligned_s;
  assign mem_be_s     = lane_be(eff_atype_s, eff_addr_s[1:0]);

  // Byte stores replicate bits [7:0] onto every lane; the enable picks one.
  always_comb begin
    if (eff_atype_s == A_BYTE) begin
      mem_wdata_s = {4{eff_wdata_s[7:0]}};
    end else begin
      mem_wdata_s = eff_wdata_s;
    end
  end

  dmem_array #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we_s),
    .be    (mem_be_s),
    .addr  (eff_addr_s[ADDR_BITS-1:2]),
    .wdata (mem_wdata_s),
    .rdata (mem_rdata_s)
  );

  // Little-endian byte-lane select for byte loads.
  always_comb begin
    case (eff_addr_s[1:0])
      2'd0:    byte_s = mem_rdata_s[7:0];
      2'd1:    byte_s = mem_rdata_s[15:8];
      2'd2:    byte_s = mem_rdata_s[23:16];
      2'd3:    byte_s = mem_rdata_s[31:24];
      default: byte_s = 8'h00;
    endcase
  end

  // Load data selection: zero-extended byte or full word.
  always_comb begin
    if (eff_atype_s == A_BYTE) begin
      load_data_s = {{(WIDTH-8){1'b0}}, byte_s};
    end else begin
      load_data_s = mem_rdata_s;
    end
  end

  // Response payload, non-zero only for the cycle spent in RESP.
  always_comb begin
    rsp_rdata_next_s = {WIDTH{1'b0}};
    rsp_err_next_s   = 1'b0;
    if (enter_resp_s) begin
      rsp_err_next_s = misaligned_s;
      if (!eff_we_s && !misaligned_s) begin
        rsp_rdata_next_s = load_data_s;
      end else begin
        rsp_rdata_next_s = {WIDTH{1'b0}};
      end
    end else begin
      rsp_rdata_next_s = {WIDTH{1'b0}};
      rsp_err_next_s   = 1'b0;
    end
  end

  // Request latch plus registered handshake/response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we_r    <= 1'b0;
      lat_atype_r <= A_WORD;
      lat_addr_r  <= {ADDR_BITS{1'b0}};
      lat_wdata_r <= {WIDTH{1'b0}};
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        lat_we_r    <= bus.req_we;
        lat_atype_r <= atype_t'(bus.req_atype);
        lat_addr_r  <= bus.req_addr[ADDR_BITS-1:0];
        lat_wdata_r <= bus.req_wdata;
      end
      req_ready_r <= (state_next_s == IDLE);
      rsp_valid_r <= enter_resp_s;
      rsp_err_r   <= rsp_err_next_s;
      rsp_rdata_r <= rsp_rdata_next_s;
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  // Dropped in RESP so the pipeline advances while the data is valid.
  assign bus.busy      = ((state_r == IDLE) && bus.req_valid) || (state_r == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (LATENCY 1, 2, 3) driven by directed
// and random load/store traffic and compared against a word-array model.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_responder_if #(.WIDTH(32)) bus1 ();
  dmem_responder_if #(.WIDTH(32)) bus2 ();
  dmem_responder_if #(.WIDTH(32)) bus3 ();

  dmem_responder #(.WIDTH(32), .ADDR_BITS(12), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(bus1));
  dmem_responder #(.WIDTH(32), .ADDR_BITS(12), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(bus2));
  dmem_responder #(.WIDTH(32), .ADDR_BITS(12), .LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .bus(bus3));

  // Per-instance drive (index 0 -> LATENCY 1, 1 -> 2, 2 -> 3).
  logic [2:0]  rv_a, rwe_a, rat_a;
  logic [31:0] raddr_a [3];
  logic [31:0] rwd_a   [3];
  logic [2:0]  rdy_v, vld_v, err_v, busy_v;
  logic [31:0] rd_v [3];

  assign bus1.req_valid = rv_a[0];  assign bus1.req_we = rwe_a[0];  assign bus1.req_atype = rat_a[0];
  assign bus1.req_addr  = raddr_a[0]; assign bus1.req_wdata = rwd_a[0];
  assign bus2.req_valid = rv_a[1];  assign bus2.req_we = rwe_a[1];  assign bus2.req_atype = rat_a[1];
  assign bus2.req_addr  = raddr_a[1]; assign bus2.req_wdata = rwd_a[1];
  assign bus3.req_valid = rv_a[2];  assign bus3.req_we = rwe_a[2];  assign bus3.req_atype = rat_a[2];
  assign bus3.req_addr  = raddr_a[2]; assign bus3.req_wdata = rwd_a[2];

  assign rdy_v  = {bus3.req_ready, bus2.req_ready, bus1.req_ready};
  assign vld_v  = {bus3.rsp_valid, bus2.rsp_valid, bus1.rsp_valid};
  assign err_v  = {bus3.rsp_err,   bus2.rsp_err,   bus1.rsp_err};
  assign busy_v = {bus3.busy,      bus2.busy,      bus1.busy};
  assign rd_v[0] = bus1.rsp_rdata;
  assign rd_v[1] = bus2.rsp_rdata;
  assign rd_v[2] = bus3.rsp_rdata;

  // Reference memory: one 1024-word image per instance.
  logic [31:0] ref_mem [3][1024];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      check({tag, "_ready"}, {31'd0, rdy_v[d]},  32'd1);
      check({tag, "_valid"}, {31'd0, vld_v[d]},  32'd0);
      check({tag, "_busy"},  {31'd0, busy_v[d]}, 32'd0);
      check({tag, "_err"},   {31'd0, err_v[d]},  32'd0);
      check({tag, "_rdata"}, rd_v[d],            32'd0);
    end
  endtask

  // One complete transaction on instance d, checked against the model.
  task automatic txn(input int d, input logic we, input logic at,
                     input logic [31:0] addr, input logic [31:0] wdata);
    int          lat;
    int          idx;
    int          lane;
    bit          seen;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] mask;
    lat     = d + 1;
    idx     = int'((addr % 32'd4096) / 32'd4);
    lane    = int'(addr % 32'd4);
    exp_err = (at == 1'b0) && (lane != 0);
    exp_rd  = 32'd0;
    if (!exp_err) begin
      if (we) begin
        if (at) begin
          mask = 32'hFF << (lane * 8);
          ref_mem[d][idx] = (ref_mem[d][idx] & ~mask) | ({24'd0, wdata[7:0]} << (lane * 8));
        end else begin
          ref_mem[d][idx] = wdata;
        end
      end else if (at) begin
        exp_rd = (ref_mem[d][idx] >> (lane * 8)) & 32'hFF;
      end else begin
        exp_rd = ref_mem[d][idx];
      end
    end

    @(negedge clk);
    rv_a[d] = 1'b1; rwe_a[d] = we; rat_a[d] = at; raddr_a[d] = addr; rwd_a[d] = wdata;
    #1;
    check("accept_ready", {31'd0, rdy_v[d]},  32'd1);
    check("accept_busy",  {31'd0, busy_v[d]}, 32'd1);
    @(posedge clk);
    #1;
    rv_a[d] = 1'b0;
    seen = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (vld_v[d]) begin
        seen = 1'b1;
        check("latency",    n,                  lat);
        check("rsp_rdata",  rd_v[d],            exp_rd);
        check("rsp_err",    {31'd0, err_v[d]},  {31'd0, exp_err});
        check("resp_busy",  {31'd0, busy_v[d]}, 32'd0);
        check("resp_ready", {31'd0, rdy_v[d]},  32'd0);
        rv_a[d] = 1'b0;
      end else begin
        check("wait_busy",  {31'd0, busy_v[d]}, 32'd1);
        check("wait_ready", {31'd0, rdy_v[d]},  32'd0);
        // Junk request while busy: must be ignored.
        rv_a[d] = 1'b1; rwe_a[d] = 1'b1; rat_a[d] = $urandom_range(0, 1);
        raddr_a[d] = $urandom; rwd_a[d] = $urandom;
      end
    end
    if (!seen) check("rsp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("post_valid", {31'd0, vld_v[d]}, 32'd0);
    check("post_ready", {31'd0, rdy_v[d]}, 32'd1);
    check("post_rdata", rd_v[d],           32'd0);
    check("post_err",   {31'd0, err_v[d]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rv_a = 3'b000; rwe_a = 3'b000; rat_a = 3'b000;
    for (int d = 0; d < 3; d++) begin
      raddr_a[d] = 32'd0;
      rwd_a[d]   = 32'd0;
    end
    rst = 1'b1;
    #2 rst = 1'b0;

    // Reset held for three cycles, then idle for three.
    repeat (3) begin
      @(negedge clk);
      check_idle_all("in_reset");
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle_all("idle");
    end

    // Word store/load on LATENCY=2.
    txn(1, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    txn(1, 1'b0, 1'b0, 32'h0000_0010, 32'h0);

    // Byte lanes.
    txn(1, 1'b1, 1'b0, 32'h0000_0020, 32'h1122_3344);
    txn(1, 1'b1, 1'b1, 32'h0000_0022, 32'h0000_00AB);
    txn(1, 1'b0, 1'b0, 32'h0000_0020, 32'h0);
    check("model_lane", ref_mem[1][8], 32'h11AB_3344);
    txn(1, 1'b0, 1'b1, 32'h0000_0023, 32'h0);

    // Misaligned word store and load leave memory unchanged.
    txn(1, 1'b1, 1'b0, 32'h0000_0030, 32'h600D_CAFE);
    txn(1, 1'b1, 1'b0, 32'h0000_0031, 32'h0000_0055);
    txn(1, 1'b0, 1'b0, 32'h0000_0030, 32'h0);
    txn(1, 1'b0, 1'b0, 32'h0000_0032, 32'h0);

    // Address wrap on LATENCY=1.
    txn(0, 1'b1, 1'b0, 32'h0000_1004, 32'h1234_5678);
    txn(0, 1'b0, 1'b0, 32'h0000_0004, 32'h0);
    check("model_wrap", ref_mem[0][1], 32'h1234_5678);

    // Reset in the first WAIT cycle of a LATENCY=3 store.
    txn(2, 1'b1, 1'b0, 32'h0000_0040, 32'h0BAD_BEEF);
    @(negedge clk);
    rv_a[2] = 1'b1; rwe_a[2] = 1'b1; rat_a[2] = 1'b0;
    raddr_a[2] = 32'h0000_0040; rwd_a[2] = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    rv_a[2] = 1'b0;
    @(negedge clk);
    check("abort_wait_busy", {31'd0, busy_v[2]}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_ready", {31'd0, rdy_v[2]},  32'd1);
    check("abort_busy",  {31'd0, busy_v[2]}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort_valid_rst", {31'd0, vld_v[2]}, 32'd0);
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_valid_after", {31'd0, vld_v[2]}, 32'd0);
    end
    txn(2, 1'b0, 1'b0, 32'h0000_0040, 32'h0);

    // Random traffic over words 0x100..0x13C (upper address bits random).
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) begin
        txn(d, 1'b1, 1'b0, 32'h0000_0100 + 32'(w * 4), $urandom);
      end
    end
    for (int k = 0; k < 60; k++) begin
      int          d;
      logic [31:0] a;
      d = int'($urandom_range(0, 2));
      a = ($urandom & 32'hFFFF_F000) | (32'h0000_0100 + 32'($urandom_range(0, 63)));
      txn(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
